// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a 5-stage RV32I pipeline, together with the
// operand-forwarding network and the load-use hazard detector.
//
// The stage registers the decoded instruction coming out of ID. In EX it
// resolves the registered rs1/rs2 values against the results currently held
// in the MEM and WB stages. From those resolved values it drives the ALU
// operands and the store data.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   id_*                decoded instruction fields from ID
//   mem_reg_write/rd/result, wb_reg_write/rd/result
//                       producer information used for forwarding
//   flush               redirect from branch resolution; kills EX contents
//   ex_hold             downstream stall; freezes EX
//   stall_id            ID/IF must not advance this cycle
//   ex_*                execute-stage instruction, ALU operands, store data
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [1:0]       id_a_sel,
  input  logic             id_b_sel,
  input  logic [3:0]       id_alu_f,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,

  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_result,

  input  logic             flush,
  input  logic             ex_hold,

  output logic             stall_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [XLEN-1:0]  ex_alu_a,
  output logic [XLEN-1:0]  ex_alu_b,
  output logic [3:0]       ex_alu_f,
  output logic [XLEN-1:0]  ex_store_data
);

  // ALU A source encodings (2'd3 falls back to zero)
  localparam logic [1:0] A_SEL_RS1 = 2'd0;
  localparam logic [1:0] A_SEL_PC  = 2'd1;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             ex_valid_r;
  logic [XLEN-1:0]  ex_pc_r;
  logic [4:0]       ex_rd_r;
  logic [4:0]       ex_rs1_r;
  logic [4:0]       ex_rs2_r;
  logic [XLEN-1:0]  rs1_val_r;
  logic [XLEN-1:0]  rs2_val_r;
  logic [XLEN-1:0]  imm_r;
  logic [1:0]       a_sel_r;
  logic             b_sel_r;
  logic [3:0]       alu_f_r;
  logic             reg_write_r;
  logic             mem_read_r;
  logic             mem_write_r;

  // Combinational intermediates
  logic [XLEN-1:0]  fwd_rs1_s;
  logic [XLEN-1:0]  fwd_rs2_s;
  logic             load_use_s;
  logic             stall_id_s;
  logic [XLEN-1:0]  alu_a_s;
  logic [XLEN-1:0]  alu_b_s;

  // ---------------------------------------------------------------------------
  // Resolve one source operand. x0 always reads as zero. Otherwise the MEM
  // stage is the younger producer, so it beats WB. The registered value is
  // used only when neither stage writes the register.
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] stored,
    input logic            mem_we,
    input logic [4:0]      mem_dst,
    input logic [XLEN-1:0] mem_val,
    input logic            wb_we,
    input logic [4:0]      wb_dst,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] res;
    if (rs == 5'd0) begin
      res = {XLEN{1'b0}};
    end else if (mem_we && (mem_dst == rs)) begin
      res = mem_val;
    end else if (wb_we && (wb_dst == rs)) begin
      res = wb_val;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Forwarding network for both registered source operands
  always_comb begin
    fwd_rs1_s = fwd_operand(ex_rs1_r, rs1_val_r, mem_reg_write, mem_rd, mem_result,
                            wb_reg_write, wb_rd, wb_result);
    fwd_rs2_s = fwd_operand(ex_rs2_r, rs2_val_r, mem_reg_write, mem_rd, mem_result,
                            wb_reg_write, wb_rd, wb_result);
  end

  // Load-use detection. The ID instruction needs the load result before it exists.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_valid_r && mem_read_r && (ex_rd_r != 5'd0) && id_valid) begin
      load_use_s = (id_rs1_used && (id_rs1 == ex_rd_r)) ||
                   (id_rs2_used && (id_rs2 == ex_rd_r));
    end else begin
      load_use_s = 1'b0;
    end
    // A redirect discards the ID instruction anyway, so it never needs to wait.
    stall_id_s = (load_use_s || ex_hold) && !flush;
  end

  // ALU operand selection from the registered selects
  always_comb begin
    alu_a_s = {XLEN{1'b0}};
    case (a_sel_r)
      A_SEL_RS1: alu_a_s = fwd_rs1_s;
      A_SEL_PC:  alu_a_s = ex_pc_r;
      default:   alu_a_s = {XLEN{1'b0}};
    endcase
    if (b_sel_r) begin
      alu_b_s = imm_r;
    end else begin
      alu_b_s = fwd_rs2_s;
    end
  end

  // ID/EX register update: reset > flush > hold > load-use bubble > capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_r  <= 1'b0;
      ex_pc_r     <= RESET_PC;
      ex_rd_r     <= 5'd0;
      ex_rs1_r    <= 5'd0;
      ex_rs2_r    <= 5'd0;
      rs1_val_r   <= {XLEN{1'b0}};
      rs2_val_r   <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      a_sel_r     <= 2'd0;
      b_sel_r     <= 1'b0;
      alu_f_r     <= 4'd0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r  <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (ex_hold) begin
      // Latch the forwarded operands while frozen. A producer can then retire
      // from WB during a long hold and the operand still stays current.
      rs1_val_r   <= fwd_rs1_s;
      rs2_val_r   <= fwd_rs2_s;
    end else if (load_use_s) begin
      ex_valid_r  <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      ex_valid_r  <= id_valid;
      ex_pc_r     <= id_pc;
      ex_rd_r     <= id_rd;
      ex_rs1_r    <= id_rs1;
      ex_rs2_r    <= id_rs2;
      rs1_val_r   <= id_rs1_val;
      rs2_val_r   <= id_rs2_val;
      imm_r       <= id_imm;
      a_sel_r     <= id_a_sel;
      b_sel_r     <= id_b_sel;
      alu_f_r     <= id_alu_f;
      reg_write_r <= id_reg_write && id_valid;
      mem_read_r  <= id_mem_read  && id_valid;
      mem_write_r <= id_mem_write && id_valid;
    end
  end

  // Output drive. Controls are also gated with valid so that a bubble can
  // never issue a write.
  always_comb begin
    stall_id      = stall_id_s;
    ex_valid      = ex_valid_r;
    ex_pc         = ex_pc_r;
    ex_rd         = ex_rd_r;
    ex_reg_write  = reg_write_r && ex_valid_r;
    ex_mem_read   = mem_read_r  && ex_valid_r;
    ex_mem_write  = mem_write_r && ex_valid_r;
    ex_alu_a      = alu_a_s;
    ex_alu_b      = alu_b_s;
    ex_alu_f      = alu_f_r;
    ex_store_data = fwd_rs2_s;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. It runs directed scenarios first and
// then randomized traffic. A behavioural model of the EX slot predicts every
// output. The model holds the instruction in EX as a record and applies the
// stage rules directly.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used;
  logic [31:0]      id_rs1_val, id_rs2_val, id_imm;
  logic [1:0]       id_a_sel;
  logic             id_b_sel;
  logic [3:0]       id_alu_f;
  logic             id_reg_write, id_mem_read, id_mem_write;
  logic             mem_reg_write;
  logic [4:0]       mem_rd;
  logic [31:0]      mem_result;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_result;
  logic             flush, ex_hold;
  logic             stall_id, ex_valid;
  logic [31:0]      ex_pc;
  logic [4:0]       ex_rd;
  logic             ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0]      ex_alu_a, ex_alu_b, ex_store_data;
  logic [3:0]       ex_alu_f;

  id_ex_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_f(id_alu_f),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .ex_hold(ex_hold),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_f(ex_alu_f),
    .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in EX, as a plain record
  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] v1, v2, imm;
    logic [1:0]  asel;
    bit          bsel;
    logic [3:0]  f;
    bit          rw, mr, mw;
  } ex_slot_t;

  ex_slot_t m;

  function automatic ex_slot_t slot_after_reset();
    ex_slot_t s;
    s = '{v: 1'b0, pc: RESET_PC, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, v1: 32'd0, v2: 32'd0,
          imm: 32'd0, asel: 2'd0, bsel: 1'b0, f: 4'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
    return s;
  endfunction

  // Architectural value of register r as EX sees it this cycle
  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] stored);
    if (r == 5'd0) return 32'd0;
    if (mem_reg_write && mem_rd == r) return mem_result;
    if (wb_reg_write && wb_rd == r) return wb_result;
    return stored;
  endfunction

  // Check outputs for the current inputs, then advance the model across one edge
  task automatic step();
    bit lu;
    bit exp_stall;
    logic [31:0] a_exp, b_exp, s_exp;
    #1;
    if (reset) m = slot_after_reset();
    lu = m.v && m.mr && (m.rd != 5'd0) && id_valid &&
         ((id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd));
    exp_stall = (lu || ex_hold) && !flush;
    s_exp = reg_value(m.rs2, m.v2);
    a_exp = (m.asel == 2'd0) ? reg_value(m.rs1, m.v1) : (m.asel == 2'd1) ? m.pc : 32'd0;
    b_exp = m.bsel ? m.imm : s_exp;

    chk("ex_valid",  32'(ex_valid),     32'(m.v));
    chk("stall_id",  32'(stall_id),     32'(exp_stall));
    chk("reg_write", 32'(ex_reg_write), 32'(m.v && m.rw));
    chk("mem_read",  32'(ex_mem_read),  32'(m.v && m.mr));
    chk("mem_write", 32'(ex_mem_write), 32'(m.v && m.mw));
    if (m.v) begin
      chk("ex_pc",      ex_pc,         m.pc);
      chk("ex_rd",      32'(ex_rd),    32'(m.rd));
      chk("alu_f",      32'(ex_alu_f), 32'(m.f));
      chk("alu_a",      ex_alu_a,      a_exp);
      chk("alu_b",      ex_alu_b,      b_exp);
      chk("store_data", ex_store_data, s_exp);
    end

    if (reset) begin
      m = slot_after_reset();
    end else if (flush) begin
      m.v = 1'b0;
    end else if (ex_hold) begin
      m.v1 = reg_value(m.rs1, m.v1);
      m.v2 = reg_value(m.rs2, m.v2);
    end else if (lu) begin
      m.v = 1'b0;
    end else begin
      m = '{v: id_valid, pc: id_pc, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
            v1: id_rs1_val, v2: id_rs2_val, imm: id_imm, asel: id_a_sel,
            bsel: id_b_sel, f: id_alu_f, rw: id_reg_write, mr: id_mem_read,
            mw: id_mem_write};
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_pc = 32'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rs1_val = 32'd0; id_rs2_val = 32'd0;
    id_imm = 32'd0; id_a_sel = 2'd0; id_b_sel = 1'b0; id_alu_f = 4'd0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    flush = 1'b0; ex_hold = 1'b0;
  endtask

  task automatic randomize_inputs();
    reset = ($urandom_range(0, 59) == 0);
    id_valid = ($urandom_range(0, 4) != 0);
    id_pc = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7));
    id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
    id_rs1_val = $urandom; id_rs2_val = $urandom;
    id_a_sel = 2'($urandom); id_b_sel = 1'($urandom); id_alu_f = 4'($urandom);
    id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = ($urandom_range(0, 3) == 0);
    mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
    wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
    flush = ($urandom_range(0, 9) == 0);
    ex_hold = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    // Reset state, held across an edge, then released with an empty ID
    set_idle();
    reset = 1'b1;
    m = slot_after_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc",    ex_pc,         RESET_PC);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_ctrl",  32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
    reset = 1'b0;
    step();
    step();

    // MEM forwards rs1, WB forwards rs2
    set_idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd6; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    id_rd = 5'd10; id_reg_write = 1'b1; id_pc = 32'h0000_0040;
    step();
    set_idle();
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'h11;
    wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'h22;
    #1;
    chk("fwd_mem_a", ex_alu_a, 32'h11);
    chk("fwd_wb_b",  ex_alu_b, 32'h22);
    step();

    // MEM beats WB on the same register; x0 is always zero
    set_idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rd = 5'd9;
    step();
    set_idle();
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'hAA;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'hBB;
    #1;
    chk("fwd_prio", ex_alu_a, 32'hAA);
    step();
    set_idle();
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1; id_rs1_val = 32'h1234;
    step();
    set_idle();
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hAA;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hBB;
    #1;
    chk("fwd_x0", ex_alu_a, 32'd0);
    step();

    // Load-use: LW x7 in EX, ADD reading x7 in ID
    set_idle();
    id_valid = 1'b1; id_rd = 5'd7; id_rs1 = 5'd1; id_rs1_used = 1'b1;
    id_mem_read = 1'b1; id_reg_write = 1'b1; id_b_sel = 1'b1; id_imm = 32'd4;
    step();
    set_idle();
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd2; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    id_rd = 5'd8; id_reg_write = 1'b1; id_pc = 32'h0000_0080;
    #1;
    chk("lu_stall", 32'(stall_id), 32'd1);
    step();
    #1;
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_release", 32'(stall_id), 32'd0);
    step();
    set_idle();
    mem_reg_write = 1'b1; mem_rd = 5'd7; mem_result = 32'hDEAD_BEEF;
    #1;
    chk("lu_capture", 32'(ex_valid), 32'd1);
    chk("lu_fwd", ex_alu_a, 32'hDEAD_BEEF);
    step();

    // Hold refresh: WB retires x3 during the first of three hold cycles
    set_idle();
    id_valid = 1'b1; id_rs2 = 5'd3; id_rs2_used = 1'b1; id_mem_write = 1'b1;
    id_b_sel = 1'b1; id_imm = 32'd8;
    step();
    set_idle();
    ex_hold = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h55;
    #1;
    chk("hold_stall", 32'(stall_id), 32'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      wb_reg_write = 1'b0; wb_result = 32'd0;
      #1;
      chk("hold_store", ex_store_data, 32'h55);
      step();
    end

    // flush together with hold and a valid ID instruction
    set_idle();
    id_valid = 1'b1; id_rd = 5'd4; id_reg_write = 1'b1;
    step();
    id_rd = 5'd5; flush = 1'b1; ex_hold = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_id), 32'd0);
    step();
    set_idle();
    #1;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
